// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width, tap mask, step function and scheduler states
package lfsr_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;
  typedef enum logic [1:0] {LOAD, WARM, SERVE} state_t;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction
endpackage

// File: rtl/lfsr_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx
);
  logic hit;
  int j;
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    j = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (en && !hit && req[j]) begin
        hit = 1'b1;
        win[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/lfsr_share_arb.sv
// lfsr_share_arb: round-robin distribution of one 8-bit LFSR stream, one value per grant
module lfsr_share_arb
  import lfsr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter logic [LFSR_W-1:0] DEF_SEED = 8'hA5,
  parameter int WARMUP = 8,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              seed_we,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd_data,
  output logic [IW-1:0]     rnd_id,
  output logic              busy,
  output logic              seed_zero,
  output logic              wrap
);
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr, ld_seed, nxt, cnt;
  logic [7:0] wcnt;
  logic [IW-1:0] ptr, idx;
  logic [NREQ-1:0] win;
  logic step;
  assign nxt = lfsr_next(lfsr);
  assign step = !seed_we && (state == WARM || (state == SERVE && |req));
  assign busy = state != SERVE;
  assign rnd_valid = |gnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .en (state == SERVE && !seed_we),
    .win(win),
    .idx(idx)
  );
  always_comb begin
    state_n = seed_we ? LOAD
            : state == LOAD ? (WARMUP == 0 ? SERVE : WARM)
            : (state == WARM && wcnt == 8'(WARMUP - 1)) ? SERVE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else state <= state_n;
  end
  // ld_seed doubles as the pending seed: a write lands here, LOAD copies it into the LFSR
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= DEF_SEED;
      ld_seed <= DEF_SEED;
      cnt <= '0;
      wcnt <= '0;
      ptr <= IW'(NREQ - 1);
      gnt <= '0;
      rnd_data <= '0;
      rnd_id <= '0;
      seed_zero <= 1'b0;
      wrap <= 1'b0;
    end else begin
      gnt <= win;
      wrap <= step && nxt == ld_seed;
      if (seed_we) begin
        ld_seed <= seed_in == '0 ? DEF_SEED : seed_in;
        seed_zero <= seed_in == '0;
      end
      if (state == LOAD) begin
        lfsr <= ld_seed;
        cnt <= '0;
        wcnt <= '0;
      end
      if (state == WARM) wcnt <= wcnt + 1'b1;
      if (step) begin
        lfsr <= nxt;
        cnt <= nxt == ld_seed ? '0 : cnt + 1'b1;
      end
      if (|win) begin
        rnd_data <= lfsr;
        rnd_id <= idx;
        ptr <= idx;
      end
    end
  end
endmodule
